// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: state codes,
// control levels and constants.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic        DIV_START            = 1'b1;
  localparam logic        DIV_STOP             = 1'b0;
  localparam logic        RST_ENABLE           = 1'b1;
  localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;
  localparam logic [5:0]  DIV_ITERS            = 6'd32;

  function automatic logic [31:0] abs_if_signed(input logic sgn, input logic [31:0] v);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Optional abort of an in-flight division is enabled by defining DIV_ANNUL_EN.
//
// state       | meaning
// DIV_FREE    | idle, waiting for start_i
// DIV_BY_ZERO | divisor was zero, report zero result next edge
// DIV_ON      | 32 restoring iterations, then sign fixup
// DIV_END     | result valid, held until start_i drops
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_d;
  logic        ready_d;
  logic        annul_act;
  logic [32:0] partial;
  logic [32:0] diff;

`ifdef DIV_ANNUL_EN
  assign annul_act = annul_i;
`else
  logic unused_annul;
  assign unused_annul = annul_i;
  assign annul_act    = 1'b0;
`endif

  // Partial remainder is below the divisor, so bit 32 of the 33-bit
  // difference is set exactly when the trial subtraction goes negative.
  assign partial = {rem_q, dvd_q[31]};
  assign diff    = partial - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_o;
    ready_d   = ready_o;
    case (state_q)
      DIV_FREE: begin
        result_d = {ZERO_WORD, ZERO_WORD};
        ready_d  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && !annul_act) begin
          if (opdata2_i == ZERO_WORD) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d   = DIV_ON;
            cnt_d     = 6'd0;
            rem_d     = ZERO_WORD;
            dvd_d     = abs_if_signed(signed_div_i, opdata1_i);
            dvs_d     = abs_if_signed(signed_div_i, opdata2_i);
            neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d = signed_div_i && opdata1_i[31];
          end
        end
      end
      DIV_BY_ZERO: begin
        result_d = {ZERO_WORD, ZERO_WORD};
        if (annul_act) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          ready_d = DIV_RESULT_READY;
        end
      end
      DIV_ON: begin
        if (annul_act) begin
          state_d  = DIV_FREE;
          cnt_d    = 6'd0;
          result_d = {ZERO_WORD, ZERO_WORD};
          ready_d  = DIV_RESULT_NOT_READY;
        end else if (cnt_q != DIV_ITERS) begin
          if (!diff[32]) begin
            rem_d = diff[31:0];
            dvd_d = {dvd_q[30:0], 1'b1};
          end else begin
            rem_d = partial[31:0];
            dvd_d = {dvd_q[30:0], 1'b0};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          // dvd_q now holds the magnitude quotient, rem_q the magnitude remainder
          result_d = {neg_rem_q ? (~rem_q + 32'd1) : rem_q,
                      neg_quo_q ? (~dvd_q + 32'd1) : dvd_q};
          ready_d  = DIV_RESULT_READY;
          state_d  = DIV_END;
          cnt_d    = 6'd0;
        end
      end
      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_d  = DIV_FREE;
          result_d = {ZERO_WORD, ZERO_WORD};
          ready_d  = DIV_RESULT_NOT_READY;
        end
      end
      default: state_d = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= 6'd0;
      dvd_q     <= ZERO_WORD;
      rem_q     <= ZERO_WORD;
      dvs_q     <= ZERO_WORD;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= {ZERO_WORD, ZERO_WORD};
      ready_o   <= DIV_RESULT_NOT_READY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high (1'b1 = RstEnable).
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 selects signed (div), 0 selects unsigned (divu).
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend, from EX reg1 operand.
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor, from EX reg2 operand.
REQ-006 SHALL have port start_i, input, 1 bit: EX request; held high until ready_o is seen.
REQ-007 SHALL have port annul_i, input, 1 bit: abort the division in progress.
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}, registered.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o valid, registered.

Function
REQ-010 SHALL implement a four-state FSM: DivFree, DivByZero, DivOn, DivEnd.
REQ-011 DivFree: if start_i=1, annul_i=0 and opdata2_i=0, SHALL go to DivByZero; if start_i=1, annul_i=0 and opdata2_i!=0, SHALL go to DivOn with cnt=0; otherwise SHALL stay, with ready_o=0 and result_o=0.
REQ-012 On the DivFree->DivOn edge, SHALL latch operand magnitudes: the two's-complement absolute value when signed_div_i=1 and bit31=1, the raw value otherwise.
REQ-013 DivOn: each edge SHALL perform one restoring step (shift partial remainder left 1 and take the next dividend bit; trial-subtract the divisor magnitude as 33-bit; if non-negative, keep the difference and set the quotient bit to 1, else quotient bit 0), then cnt+1.
REQ-014 DivOn: the edge after cnt reaches 32 SHALL apply sign fixups, load result_o, set ready_o=1 and enter DivEnd.
 - Signed quotient is negated when the dividend and divisor signs differ.
 - Signed remainder is negated when the dividend is negative.
 - Unsigned: no fixup.
REQ-015 Latency: from the start edge, ready_o SHALL be visible after 34 edges (1 launch, 32 iterations, 1 finalize).
REQ-016 DivByZero: next edge SHALL enter DivEnd with result_o=0 and ready_o=1, visible after 2 edges from start.
REQ-017 DivEnd: SHALL hold result_o and ready_o while start_i=1; on an edge with start_i=0 SHALL clear both and return to DivFree.
REQ-018 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (no trap).
REQ-019 Operand inputs SHALL be ignored outside the launch edge; EX may change them mid-division without effect.
REQ-020 A new division SHALL NOT start until the FSM has returned to DivFree (minimum one idle edge after DivEnd).

Reset
REQ-021 rst=1 at an edge SHALL force DivFree, cnt=0, ready_o=0 and result_o=0, overriding all other inputs including mid-division; rst has no asynchronous effect.

Configuration
REQ-022 DIV_ANNUL_EN defined:
 - annul_i=1 in DivOn or DivByZero SHALL return to DivFree on the next edge, with ready_o=0 and result_o=0.
 - annul_i=1 in DivFree SHALL block a start.
REQ-023 DIV_ANNUL_EN undefined: annul_i SHALL remain a port but be ignored, and every launched division runs to DivEnd.

Structure
REQ-024 The shared defines file SHALL hold the state codes, each 2 bits:
 - DivFree=00, DivByZero=01, DivOn=10, DivEnd=11
 - DivResultReady/DivResultNotReady, DivStart/DivStop, ZeroWord, RstEnable
REQ-025 The block SHALL be a single module with no sub-module; the 33-bit trial subtractor is inline combinational logic.

Verification
REQ-026 Unsigned 100/7 (0x64/0x7) -> result_o=0x00000002_0000000E, ready_o high after exactly 34 edges; drop start_i -> ready_o=0 next edge.
REQ-027 Signed -7/2 (0xFFFFFFF9/0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x1.
REQ-028 Divisor 0 (5/0) -> DivByZero then DivEnd, result_o=0, ready_o high after 2 edges.
REQ-029 With DIV_ANNUL_EN, annul_i pulsed at iteration 10 of 1000/3 -> DivFree, ready_o never rises; next start 9/3 -> quotient 3, remainder 0.
REQ-030 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-031 rst=1 at iteration 20 -> next edge DivFree, ready_o=0, result_o=0; a following 10/4 -> quotient 2, remainder 2.
